// File: rtl/uart_rx_fifo_os_if.sv
// Host-side signal bundle of the oversampled UART receiver: the serial pin, the
// parity mode, the read strobe and the FIFO and status outputs.
interface uart_rx_fifo_os_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx;
  logic [1:0]           Parity_Mode;
  logic                 Read_Done;
  logic [DATA_BITS-1:0] Data_Out;
  logic                 Data_Rdy;
  logic                 FIFO_Empty;
  logic                 FIFO_Full;
  logic                 FIFO_Overflow;
  logic                 RTS;
  logic [2:0]           Rx_Error;

  modport master (output Rx, Parity_Mode, Read_Done,
                  input  Data_Out, Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, Rx_Error);
  modport slave  (input  Rx, Parity_Mode, Read_Done,
                  output Data_Out, Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, Rx_Error);
endinterface

// File: rtl/uart_rx_fifo_os.sv
// Oversampled UART receiver with runtime parity mode, false-start rejection and
// break/parity/frame detection. Good frames are pushed into a small FIFO.
module uart_rx_fifo_os #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int OVERSAMPLE  = 16,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int FULL_THRESH = FIFO_DEPTH/2+1
)(
  input  logic               Clk,
  input  logic               Rst,
  uart_rx_fifo_os_if.slave   bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS+1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW+1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

  state_t               state, state_n;
  logic                 rx_s1, rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 cnt_clr, samp, latch, done;
  logic [1:0]           mode_l;
  logic [DATA_BITS-1:0] shreg;
  logic                 any_one, stop_err, par_bit;
  logic                 par_en, par_exp, brk;
  logic [2:0]           err_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [NW-1:0]        count;
  logic                 wr, pop, push;

  // Rx is asynchronous to Clk; everything downstream uses rxs only.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= bus.Rx;
      rxs   <= rx_s1;
    end
  end

  assign par_en  = (mode_l == 2'b01) || (mode_l == 2'b10);
  assign par_exp = (mode_l == 2'b01) ? ^shreg : ~^shreg;

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    samp    = 1'b0;
    latch   = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_n = S_START;
      end
      S_START: if (cnt == CW'(OVERSAMPLE/2-1)) begin
        cnt_clr = 1'b1;
        if (rxs) state_n = S_IDLE;
        else begin
          latch   = 1'b1;
          state_n = S_DATA;
        end
      end
      S_DATA: if (cnt == CW'(OVERSAMPLE-1)) begin
        cnt_clr = 1'b1;
        samp    = 1'b1;
        if (bit_cnt == BW'(DATA_BITS-1)) state_n = par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (cnt == CW'(OVERSAMPLE-1)) begin
        cnt_clr = 1'b1;
        samp    = 1'b1;
        state_n = S_STOP;
      end
      S_STOP: if (cnt == CW'(OVERSAMPLE-1)) begin
        cnt_clr = 1'b1;
        samp    = 1'b1;
        if (bit_cnt == BW'(STOP_BITS-1)) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // bit_cnt restarts on every state change so DATA and STOP share it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      mode_l   <= 2'b00;
      shreg    <= '0;
      any_one  <= 1'b0;
      stop_err <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state_n != state) bit_cnt <= '0;
      else if (samp)        bit_cnt <= bit_cnt + 1'b1;
      if (latch) begin
        mode_l   <= bus.Parity_Mode;
        shreg    <= '0;
        any_one  <= 1'b0;
        stop_err <= 1'b0;
        par_bit  <= 1'b0;
      end else if (samp) begin
        any_one <= any_one | rxs;
        case (state)
          S_DATA:   shreg <= (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], rxs}
                                              : {rxs, shreg[DATA_BITS-1:1]};
          S_PARITY: par_bit <= rxs;
          default:  if (!rxs) stop_err <= 1'b1;
        endcase
      end
    end
  end

  // The start bit is excluded: break means the whole sampled body was low.
  assign brk   = ~any_one;
  assign err_n = {stop_err & ~brk, par_en & (par_bit != par_exp) & ~brk, brk};

  always_ff @(posedge Clk) begin
    if (Rst)       bus.Rx_Error <= 3'b000;
    else if (done) bus.Rx_Error <= err_n;
  end

  assign wr   = done && (err_n == 3'b000);
  assign pop  = bus.Read_Done && (count != '0);
  assign push = wr && ((count != NW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge Clk) begin
    if (push) mem[wp] <= shreg;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wp                <= '0;
      rp                <= '0;
      count             <= '0;
      bus.FIFO_Overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + NW'(push) - NW'(pop);
      if (wr && !push) bus.FIFO_Overflow <= 1'b1;
    end
  end

  // Head is masked while empty so Data_Out reads 0 out of reset.
  assign bus.Data_Out   = (count == '0) ? '0 : mem[rp];
  assign bus.FIFO_Empty = (count == '0);
  assign bus.Data_Rdy   = (count != '0);
  assign bus.FIFO_Full  = (count >= NW'(FULL_THRESH));
  assign bus.RTS        = ~bus.FIFO_Full;
endmodule
